// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU issue/capture stage.
package alu_pkg;

  localparam int OPND_W  = 4;
  localparam int RES_W   = 7;
  localparam int NUM_OPS = 12;
  localparam logic [RES_W-1:0] DZ_FILL = 7'h7F;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL1 = 4'd4,
    OP_SHR1 = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOR  = 4'd9,
    OP_NAND = 4'd10,
    OP_XNOR = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [3:0]       op;
    logic             dz;
    logic             err;
  } alu_entry_t;

endpackage

// File: rtl/alu_out_fifo.sv
// Small synchronous FIFO of captured ALU entries; head is read straight from storage registers.
module alu_out_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  alu_entry_t                   entry_i,
  input  logic                         pop_i,
  output alu_entry_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  alu_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  // Storage is reset too, so the head reads as all-zero while in reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else if (push_i && (wr_ptr_q == PTR_W'(gi))) begin
          mem_q[gi] <= entry_i;
        end
      end
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// Operand register feeding the external ALU, result/flag selection, and a 2-entry output queue.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPND_W-1:0]        in_a,
  input  logic [OPND_W-1:0]        in_b,
  input  logic [3:0]               in_op,
  output logic [OPND_W-1:0]        alu_a,
  output logic [OPND_W-1:0]        alu_b,
  input  logic [NUM_OPS*RES_W-1:0] alu_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RES_W-1:0]         out_result,
  output logic [3:0]               out_op,
  output logic                     out_dz,
  output logic                     out_err,
  output logic [CNT_W-1:0]         done_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [OPND_W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic              s1_valid_q, s1_valid_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

  logic              push, pop, accept;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  alu_entry_t        entry, head;
  logic [RES_W-1:0]  res_bus [NUM_OPS];

  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_res
      assign res_bus[gi] = alu_res[gi*RES_W +: RES_W];
    end
  endgenerate

  assign pop      = !fifo_empty && out_ready;
  assign push     = s1_valid_q && (!fifo_full || pop);
  assign in_ready = !s1_valid_q || push;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      a_d        = in_a;
      b_d        = in_b;
      op_d       = in_op;
      s1_valid_d = 1'b1;
    end else if (push) begin
      s1_valid_d = 1'b0;
    end
  end

  // Illegal opcodes never index the result bus; divide-by-zero overrides whatever the ALU drives.
  always_comb begin
    entry    = '0;
    entry.op = op_q;
    if (op_q >= 4'(NUM_OPS)) begin
      entry.err = 1'b1;
    end else if ((alu_op_e'(op_q) == OP_DIV) && (b_q == '0)) begin
      entry.result = DZ_FILL;
      entry.dz     = 1'b1;
    end else begin
      entry.result = res_bus[op_q];
    end
  end

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (pop) done_cnt_d = done_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      s1_valid_q <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s1_valid_q <= s1_valid_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  alu_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CW'(FIFO_DEPTH));

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign out_valid  = !fifo_empty;
  assign out_result = head.result;
  assign out_op     = head.op;
  assign out_dz     = head.dz;
  assign out_err    = head.err;
  assign done_cnt   = done_cnt_q;

endmodule
